// File: rtl/expr_sig_compactor.sv
// rtl/expr_sig_compactor.sv - MISR compactor folding result beats into one signature.
// Optional golden compare (match, mismatch_sticky) is built when EXPR_SIG_CMP_EN is defined.
module expr_sig_compactor #(
  parameter int            W    = 90,
  parameter int            CW   = 16,
  parameter logic [W-1:0]  POLY = 90'h2D,
  parameter logic [W-1:0]  SEED = 90'h0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] count,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          busy,
  output logic [CW-1:0] beats,
  output logic          sig_valid,
  input  logic          sig_ack,
`ifdef EXPR_SIG_CMP_EN
  input  logic [W-1:0]  golden,
  output logic          match,
  output logic          mismatch_sticky,
`endif
  output logic [W-1:0]  sig
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  sig_q, sig_d;
  logic [CW-1:0] beats_q, beats_d;
  logic [CW-1:0] remaining_q, remaining_d;
  logic          in_ready_q, in_ready_d;
  logic          sig_valid_q, sig_valid_d;
  logic          busy_q, busy_d;

  logic          accept;
  logic [CW-1:0] beats_inc;
  logic [W-1:0]  sig_shift;

  assign accept    = (state_q == S_RUN) && in_valid && in_ready_q;
  assign beats_inc = beats_q + {{(CW-1){1'b0}}, 1'b1};
  // Galois-style step: shift left, fold the outgoing top bit back through POLY.
  assign sig_shift = {sig_q[W-2:0], 1'b0} ^ (sig_q[W-1] ? POLY : {W{1'b0}});

  always_comb begin
    state_d     = state_q;
    sig_d       = sig_q;
    beats_d     = beats_q;
    remaining_d = remaining_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sig_d       = SEED;
          beats_d     = {CW{1'b0}};
          remaining_d = count;
          state_d     = (count == {CW{1'b0}}) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          sig_d   = sig_shift ^ in_data;
          beats_d = beats_inc;
          if (beats_inc == remaining_q) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (sig_ack) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_RUN);
    sig_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sig_q       <= SEED;
      beats_q     <= {CW{1'b0}};
      remaining_q <= {CW{1'b0}};
      in_ready_q  <= 1'b0;
      sig_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sig_q       <= sig_d;
      beats_q     <= beats_d;
      remaining_q <= remaining_d;
      in_ready_q  <= in_ready_d;
      sig_valid_q <= sig_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign sig_valid = sig_valid_q;
  assign busy      = busy_q;
  assign beats     = beats_q;
  assign sig       = sig_q;

`ifdef EXPR_SIG_CMP_EN
  logic [W-1:0] golden_q, golden_d;
  logic         match_q, match_d;
  logic         sticky_q, sticky_d;
  logic         entering_done;

  // Compare against the next signature so match is registered alongside sig_valid.
  assign entering_done = (state_d == S_DONE) && (state_q != S_DONE);

  always_comb begin
    golden_d = golden_q;
    if (state_q == S_IDLE && start) begin
      golden_d = golden;
    end
    match_d  = match_q;
    sticky_d = sticky_q;
    if (state_d != S_DONE) begin
      match_d = 1'b0;
    end else if (entering_done) begin
      match_d  = (sig_d == golden_d);
      sticky_d = sticky_q | (sig_d != golden_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      golden_q <= {W{1'b0}};
      match_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      golden_q <= golden_d;
      match_q  <= match_d;
      sticky_q <= sticky_d;
    end
  end

  assign match           = match_q;
  assign mismatch_sticky = sticky_q;
`else
  // Without the compare option the block only produces the signature.
`endif

endmodule

// File: tb/tb_expr_sig_compactor.sv
// tb/tb_expr_sig_compactor.sv - randomized bench for expr_sig_compactor against a MISR model.
module tb_expr_sig_compactor;
  localparam int           W    = 90;
  localparam int           CW   = 16;
  localparam logic [W-1:0] POLY = 90'h2D;
  localparam logic [W-1:0] SEED = 90'h0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] count;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          busy;
  logic [CW-1:0] beats;
  logic          sig_valid;
  logic          sig_ack;
  logic [W-1:0]  sig;
`ifdef EXPR_SIG_CMP_EN
  logic [W-1:0]  golden;
  logic          match;
  logic          mismatch_sticky;
  logic          sticky_exp = 1'b0;
`endif

  int n_checks = 0;
  int n_fails  = 0;
  logic [W-1:0] vec_q[$];

  expr_sig_compactor #(.W(W), .CW(CW), .POLY(POLY), .SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .busy(busy), .beats(beats), .sig_valid(sig_valid), .sig_ack(sig_ack),
`ifdef EXPR_SIG_CMP_EN
    .golden(golden), .match(match), .mismatch_sticky(mismatch_sticky),
`endif
    .sig(sig)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_vec();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  // Signature as polynomial arithmetic: multiply by x modulo the feedback, then add the beat.
  function automatic logic [W-1:0] model_sig();
    logic [W-1:0] s;
    logic         carry;
    s = SEED;
    foreach (vec_q[i]) begin
      carry = s[W-1];
      s = s << 1;
      if (carry) s = s ^ POLY;
      s = s ^ vec_q[i];
    end
    return s;
  endfunction

  // gaps: 0 = always valid, 1 = random valid, 2 = strict 1,0,1,0 toggling
  task automatic run_vec(input int cnt, input int gaps, input logic [W-1:0] gold_xor, input bit do_ack);
    logic [W-1:0] exp;
    int idx, cyc;
    bit v;
    exp = model_sig();
`ifdef EXPR_SIG_CMP_EN
    golden = exp ^ gold_xor;
`endif
    start = 1'b1;
    count = cnt[CW-1:0];
    @(negedge clk);
    start = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < cnt) begin
      if (cyc > 500) begin
        check_eq("run_timeout", 1, 0);
        break;
      end
      v = (gaps == 0) ? 1'b1 : (gaps == 2) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
      in_valid = v;
      in_data  = v ? vec_q[idx] : rand_vec();
      sig_ack  = 1'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
      if (v) begin
        idx++;
        if (idx < cnt) check_eq("beats_mid", beats, idx);
      end
    end
    in_valid = 1'b0;
    sig_ack  = 1'b0;
    check_eq("done_valid", sig_valid, 1);
    check_eq("done_sig", sig, exp);
    check_eq("done_beats", beats, cnt);
    check_eq("done_ready", in_ready, 0);
    check_eq("done_busy", busy, 1);
`ifdef EXPR_SIG_CMP_EN
    sticky_exp = sticky_exp | (gold_xor != '0);
    check_eq("match", match, (gold_xor == '0));
    check_eq("sticky", mismatch_sticky, sticky_exp);
`endif
    if (do_ack) begin
      sig_ack = 1'b1;
      @(negedge clk);
      sig_ack = 1'b0;
      check_eq("ack_valid", sig_valid, 0);
      check_eq("ack_busy", busy, 0);
      check_eq("ack_sig_hold", sig, exp);
`ifdef EXPR_SIG_CMP_EN
      check_eq("ack_sticky", mismatch_sticky, sticky_exp);
`endif
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; count = '0; in_valid = 1'b0; in_data = '0; sig_ack = 1'b0;
`ifdef EXPR_SIG_CMP_EN
    golden = '0;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_sig", sig, SEED);
    check_eq("rst_beats", beats, 0);
    check_eq("rst_ready", in_ready, 0);
    check_eq("rst_valid", sig_valid, 0);
    check_eq("rst_busy", busy, 0);

    vec_q = {90'h0};
    run_vec(1, 0, '0, 1'b1);

    vec_q = {90'h1, 90'h0};
    run_vec(2, 0, '0, 1'b0);
    in_valid = 1'b1;
    in_data  = rand_vec();
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    check_eq("done_hold_beats", beats, 2);
    check_eq("done_hold_sig", sig, 90'h2);
    sig_ack = 1'b1;
    @(negedge clk);
    sig_ack = 1'b0;

    vec_q = {90'h1 << 89, 90'h0};
    run_vec(2, 0, '0, 1'b1);
    check_eq("feedback_poly", sig, POLY);

    vec_q.delete();
    run_vec(0, 0, '0, 1'b0);
    start = 1'b1; count = 16'd5;
    @(negedge clk);
    start = 1'b0;
    check_eq("done_start_ign", sig_valid, 1);
    check_eq("done_start_beats", beats, 0);
    start = 1'b1; sig_ack = 1'b1;
    @(negedge clk);
    start = 1'b0; sig_ack = 1'b0;
    check_eq("start_ack_idle", busy, 0);
    @(negedge clk);
    check_eq("start_ack_no_run", busy, 0);

    vec_q = {rand_vec(), rand_vec(), rand_vec()};
    run_vec(3, 2, '0, 1'b1);

    // reset mid-run after two accepted beats
    start = 1'b1; count = 16'd3;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_data = rand_vec();
      @(negedge clk);
    end
    in_valid = 1'b0;
    check_eq("pre_rst_beats", beats, 2);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_sig", sig, SEED);
    check_eq("async_rst_beats", beats, 0);
    check_eq("async_rst_busy", busy, 0);
    check_eq("async_rst_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`ifdef EXPR_SIG_CMP_EN
    sticky_exp = 1'b0;
`endif

    for (int r = 0; r < 20; r++) begin
      int c;
      c = $urandom_range(1, 12);
      vec_q.delete();
      for (int k = 0; k < c; k++) vec_q.push_back(rand_vec());
      run_vec(c, 1, '0, 1'b1);
    end

`ifdef EXPR_SIG_CMP_EN
    vec_q = {90'h1, 90'h0};
    run_vec(2, 0, 90'h1, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
